// File: rtl/nrf2401_cfg_seq_if.sv
// Avalon-MM register port of the nRF2401 configuration sequencer.
interface nrf2401_cfg_seq_if;
    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    logic [7:0] writedata;
    logic [7:0] readdata;

    modport master (output address, output chipselect, output write_n,
                    output writedata, input readdata);
    modport slave  (input address, input chipselect, input write_n,
                    input writedata, output readdata);
endinterface

// File: rtl/nrf2401_cfg_seq.sv
// nRF2401 3-wire sequencer: CPU queues bytes, START shifts them out MSB first
// inside one CS window, irq follows STATUS.done.
// Optional: define NRF_CE_CTRL_EN to drive nrf_ce from CTRL.ce_level.
module nrf2401_cfg_seq #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CS_SETUP_CYC = 4,
    parameter int unsigned CS_HOLD_CYC  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    nrf2401_cfg_seq_if.slave   bus,
    output logic               nrf_cs,
    output logic               nrf_clk1,
    output logic               nrf_data,
    output logic               nrf_ce,
    output logic               irq
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = 16;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT_LO, S_SHIFT_HI, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sr_q, sr_d;
    logic [7:0]      div_q, div_d;
    logic [7:0]      clkdiv_q;
    logic            done_q, done_d, done_set_c;
    logic            ovf_q;
    logic            pop_c;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            ce_level_c;

    logic wr_c, wr_txdata_c, wr_ctrl_c, wr_status_c, wr_clkdiv_c;
    logic start_c, abort_c, fifo_empty_c, fifo_full_c, busy_c, push_ok_c;

    assign wr_c         = bus.chipselect & ~bus.write_n;
    assign wr_txdata_c  = wr_c & (bus.address == 2'd0);
    assign wr_ctrl_c    = wr_c & (bus.address == 2'd1);
    assign wr_status_c  = wr_c & (bus.address == 2'd2);
    assign wr_clkdiv_c  = wr_c & (bus.address == 2'd3);
    assign start_c      = wr_ctrl_c & bus.writedata[0];
    assign abort_c      = wr_ctrl_c & bus.writedata[1];
    assign fifo_empty_c = (count_q == '0);
    assign fifo_full_c  = (count_q == CW'(FIFO_DEPTH));
    assign busy_c       = (state_q != S_IDLE);
    // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
    assign push_ok_c    = wr_txdata_c & (~fifo_full_c | pop_c);

    // Next-state, shifter and pop decisions for the serial sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + TW'(1);
        bit_d      = bit_q;
        sr_d       = sr_q;
        div_d      = div_q;
        pop_c      = 1'b0;
        done_set_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_c && !fifo_empty_c) state_d = S_SETUP;
            end
            S_SETUP: begin
                if (cnt_q == TW'(CS_SETUP_CYC - 1)) begin
                    state_d = S_SHIFT_LO;
                    cnt_d   = '0;
                    pop_c   = 1'b1;
                    sr_d    = mem[rd_ptr_q];
                    bit_d   = 3'd0;
                    div_d   = clkdiv_q;
                end
            end
            S_SHIFT_LO: begin
                if (cnt_q == TW'(div_q)) begin
                    state_d = S_SHIFT_HI;
                    cnt_d   = '0;
                    div_d   = clkdiv_q;
                end
            end
            S_SHIFT_HI: begin
                if (cnt_q == TW'(div_q)) begin
                    cnt_d = '0;
                    div_d = clkdiv_q;
                    if (bit_q != 3'd7) begin
                        sr_d    = {sr_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        state_d = S_SHIFT_LO;
                    end else if (!fifo_empty_c) begin
                        pop_c   = 1'b1;
                        sr_d    = mem[rd_ptr_q];
                        bit_d   = 3'd0;
                        state_d = S_SHIFT_LO;
                    end else begin
                        sr_d    = {sr_q[6:0], 1'b0};
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == TW'(CS_HOLD_CYC - 1)) begin
                    state_d    = S_IDLE;
                    done_set_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_c) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            sr_d       = '0;
            pop_c      = 1'b0;
            done_set_c = 1'b0;
        end
        done_d = done_set_c ? 1'b1 : ((wr_status_c && bus.writedata[4]) ? 1'b0 : done_q);
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            div_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            div_q   <= div_d;
            done_q  <= done_d;
        end
    end

    // FIFO pointers/level, overflow flag and CLKDIV register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            clkdiv_q <= '0;
        end else begin
            if (abort_c) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_ok_c) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop_c)     rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_q + CW'(push_ok_c) - CW'(pop_c);
            end
            if (wr_txdata_c && fifo_full_c && !pop_c) ovf_q <= 1'b1;
            else if (wr_status_c && bus.writedata[3]) ovf_q <= 1'b0;
            if (wr_clkdiv_c) clkdiv_q <= bus.writedata;
        end
    end

    // FIFO storage; contents are don't-care while the level says empty.
    always_ff @(posedge clk) begin
        if (push_ok_c && !abort_c) mem[wr_ptr_q] <= bus.writedata;
    end

    // Pin and interrupt registers follow the next state so they switch with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nrf_cs   <= 1'b0;
            nrf_clk1 <= 1'b0;
            nrf_data <= 1'b0;
            irq      <= 1'b0;
        end else begin
            nrf_cs   <= (state_d != S_IDLE);
            nrf_clk1 <= (state_d == S_SHIFT_HI);
            nrf_data <= (state_d != S_IDLE) & sr_d[7];
            irq      <= done_d;
        end
    end

`ifdef NRF_CE_CTRL_EN
    logic ce_level_q;

    // CE level register and CE pin, held low for the frame plus one cycle after CS falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ce_level_q <= 1'b0;
            nrf_ce     <= 1'b0;
        end else begin
            if (wr_ctrl_c) ce_level_q <= bus.writedata[2];
            nrf_ce <= ce_level_q & (state_q == S_IDLE) & (state_d == S_IDLE);
        end
    end
    assign ce_level_c = ce_level_q;
`else
    assign ce_level_c = 1'b0;
    assign nrf_ce     = 1'b0;
`endif

    // Zero-wait-state register read mux.
    always_comb begin
        bus.readdata = 8'h00;
        case (bus.address)
            2'd1:    bus.readdata = {5'b0, ce_level_c, 1'b0, busy_c};
            2'd2:    bus.readdata = {3'b0, done_q, ovf_q, fifo_empty_c, fifo_full_c, busy_c};
            2'd3:    bus.readdata = clkdiv_q;
            default: bus.readdata = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_nrf2401_cfg_seq.sv
// Randomized self-checking bench for nrf2401_cfg_seq (frame shape vs byte model).
module tb_nrf2401_cfg_seq;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned SETUP_CYC  = 4;
    localparam int unsigned HOLD_CYC   = 4;

    logic clk;
    logic reset_n;
    logic nrf_cs, nrf_clk1, nrf_data, nrf_ce, irq;

    nrf2401_cfg_seq_if bus ();

    nrf2401_cfg_seq #(.FIFO_DEPTH(FIFO_DEPTH), .CS_SETUP_CYC(SETUP_CYC), .CS_HOLD_CYC(HOLD_CYC)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .nrf_cs(nrf_cs), .nrf_clk1(nrf_clk1), .nrf_data(nrf_data), .nrf_ce(nrf_ce), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Byte model: everything the CPU has queued that the radio should receive.
    logic [7:0] model_q[$];

    // Pin monitor, sampled on the falling edge.
    int cs_cycles = 0, cs_rises = 0, cs_falls = 0, clk1_rises = 0, ce_in_cs = 0, ce_high = 0, cur_hi = 0;
    bit prev_cs = 0, prev_clk1 = 0, ce_at_fall = 0, ce_after_fall = 0, ce_pend = 0;
    bit rise_bits[$];
    int hi_widths[$];

    always @(negedge clk) begin
        if (ce_pend) begin ce_after_fall <= (nrf_ce === 1'b1); ce_pend <= 1'b0; end
        if (nrf_ce === 1'b1) ce_high <= ce_high + 1;
        if (nrf_cs === 1'b1) begin
            cs_cycles <= cs_cycles + 1;
            if (nrf_ce === 1'b1) ce_in_cs <= ce_in_cs + 1;
            if (!prev_cs) cs_rises <= cs_rises + 1;
        end else if (prev_cs) begin
            cs_falls   <= cs_falls + 1;
            ce_at_fall <= (nrf_ce === 1'b1);
            ce_pend    <= 1'b1;
        end
        if (nrf_clk1 === 1'b1) begin
            if (!prev_clk1) begin
                clk1_rises <= clk1_rises + 1;
                rise_bits.push_back(nrf_data === 1'b1);
                cur_hi <= 1;
            end else cur_hi <= cur_hi + 1;
        end else if (prev_clk1) hi_widths.push_back(cur_hi);
        prev_cs   <= (nrf_cs === 1'b1);
        prev_clk1 <= (nrf_clk1 === 1'b1);
    end

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        #1 d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        bus_write(2'd0, b);
        if (model_q.size() < FIFO_DEPTH) model_q.push_back(b);
    endtask

    task automatic wait_irq(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (irq === 1'b1) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Starts a frame from the queued model bytes and reports what the pins did.
    task automatic run_frame(input int d, input bit late, input logic [7:0] late_byte, input logic [7:0] cmd,
                             output int nbytes, output int cyc, output int rises, output int wins,
                             output int bit_err, output int wid_err, output bit ok);
        int c0, r0, w0, b0, h0;
        bit exp_bits[$];
        @(negedge clk); #1;
        c0 = cs_cycles; r0 = clk1_rises; w0 = cs_rises; b0 = rise_bits.size(); h0 = hi_widths.size();
        bus_write(2'd1, cmd);
        if (late) begin
            repeat (SETUP_CYC + 2) @(negedge clk);
            bus_write(2'd0, late_byte);
            model_q.push_back(late_byte);
        end
        wait_irq(16 * 20 * (d + 1) + 100, ok);
        nbytes = model_q.size();
        foreach (model_q[k]) for (int j = 7; j >= 0; j--) exp_bits.push_back(model_q[k][j]);
        model_q.delete();
        cyc = cs_cycles - c0; rises = clk1_rises - r0; wins = cs_rises - w0;
        bit_err = 0;
        foreach (exp_bits[i]) if (b0 + i >= rise_bits.size() || rise_bits[b0 + i] != exp_bits[i]) bit_err++;
        wid_err = 0;
        for (int i = h0; i < hi_widths.size(); i++) if (hi_widths[i] != d + 1) wid_err++;
    endtask

    task automatic test_reset;
        logic [7:0] r;
        reset_n = 1'b0;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if ({nrf_cs, nrf_clk1, nrf_data, nrf_ce, irq} !== 5'b0)
            begin errors++; $display("FAIL reset_outputs got=%b exp=00000", {nrf_cs, nrf_clk1, nrf_data, nrf_ce, irq}); end
        reset_n = 1'b1;
        bus_read(2'd2, r); checks++; if (r !== 8'h04) begin errors++; $display("FAIL reset_status got=%h exp=04", r); end
        bus_read(2'd1, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_ctrl got=%h exp=00", r); end
        bus_read(2'd3, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_clkdiv got=%h exp=00", r); end
        bus_read(2'd0, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_txdata got=%h exp=00", r); end
    endtask

    task automatic test_single_a5;
        int n, cyc, rises, wins, be, we; bit ok; logic [7:0] r;
        bus_write(2'd3, 8'h01);
        bus_read(2'd3, r); checks++; if (r !== 8'h01) begin errors++; $display("FAIL clkdiv_rb got=%h exp=01", r); end
        push(8'hA5);
        run_frame(1, 1'b0, 8'h00, 8'h01, n, cyc, rises, wins, be, we, ok);
        checks++; if (!ok) begin errors++; $display("FAIL a5_timeout irq never rose"); end
        checks++; if (cyc != 40) begin errors++; $display("FAIL a5_cs_cycles got=%0d exp=40", cyc); end
        checks++; if (rises != 8) begin errors++; $display("FAIL a5_pulses got=%0d exp=8", rises); end
        checks++; if (be != 0) begin errors++; $display("FAIL a5_bits got=%0d wrong exp=0", be); end
        checks++; if (we != 0) begin errors++; $display("FAIL a5_high_width got=%0d bad exp=0", we); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL a5_irq got=%b exp=1", irq); end
        bus_read(2'd2, r); checks++; if (r !== 8'h14) begin errors++; $display("FAIL a5_status got=%h exp=14", r); end
        bus_write(2'd2, 8'h10);
        bus_read(2'd2, r); checks++; if (r !== 8'h04) begin errors++; $display("FAIL done_clear got=%h exp=04", r); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_back_to_back;
        int n, cyc, rises, wins, be, we; bit ok;
        bus_write(2'd3, 8'h00);
        for (int i = 0; i < 3; i++) push(8'($urandom));
        run_frame(0, 1'b1, 8'($urandom), 8'h01, n, cyc, rises, wins, be, we, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout irq never rose"); end
        checks++; if (rises != 32) begin errors++; $display("FAIL b2b_pulses got=%0d exp=32", rises); end
        checks++; if (wins != 1) begin errors++; $display("FAIL b2b_cs_windows got=%0d exp=1", wins); end
        checks++; if (cyc != SETUP_CYC + 64 + HOLD_CYC) begin errors++; $display("FAIL b2b_cs_cycles got=%0d exp=%0d", cyc, SETUP_CYC + 64 + HOLD_CYC); end
        checks++; if (be != 0) begin errors++; $display("FAIL b2b_bits got=%0d wrong exp=0", be); end
        bus_write(2'd2, 8'h10);
    endtask

    task automatic test_random_frames;
        int n, cyc, rises, wins, be, we, d, nb; bit ok;
        for (int it = 0; it < 5; it++) begin
            d  = $urandom_range(0, 3);
            nb = $urandom_range(1, 5);
            bus_write(2'd3, 8'(d));
            for (int i = 0; i < nb; i++) push(8'($urandom));
            run_frame(d, 1'b0, 8'h00, 8'h01, n, cyc, rises, wins, be, we, ok);
            checks++; if (!ok || cyc != SETUP_CYC + 16 * nb * (d + 1) + HOLD_CYC || wins != 1)
                begin errors++; $display("FAIL rnd%0d_frame ok=%0b cyc=%0d wins=%0d exp cyc=%0d wins=1", it, ok, cyc, wins, SETUP_CYC + 16 * nb * (d + 1) + HOLD_CYC); end
            checks++; if (rises != 8 * nb || be != 0 || we != 0)
                begin errors++; $display("FAIL rnd%0d_bits pulses=%0d bit_err=%0d width_err=%0d exp pulses=%0d errs=0", it, rises, be, we, 8 * nb); end
            bus_write(2'd2, 8'h10);
        end
    endtask

    task automatic test_overflow;
        int n, cyc, rises, wins, be, we; bit ok; logic [7:0] r;
        bus_write(2'd3, 8'h00);
        for (int i = 0; i < FIFO_DEPTH + 1; i++) push(8'($urandom));
        bus_read(2'd2, r); checks++; if (r !== 8'h0A) begin errors++; $display("FAIL ovf_status got=%h exp=0a", r); end
        bus_write(2'd2, 8'h08);
        bus_read(2'd2, r); checks++; if (r !== 8'h02) begin errors++; $display("FAIL ovf_clear got=%h exp=02", r); end
        run_frame(0, 1'b0, 8'h00, 8'h01, n, cyc, rises, wins, be, we, ok);
        checks++; if (!ok || rises != 8 * FIFO_DEPTH || be != 0)
            begin errors++; $display("FAIL ovf_level ok=%0b pulses=%0d bit_err=%0d exp pulses=%0d", ok, rises, be, 8 * FIFO_DEPTH); end
        bus_write(2'd2, 8'h10);
    endtask

    task automatic test_abort;
        int r0; logic [7:0] r;
        bus_write(2'd3, 8'h01);
        for (int i = 0; i < 3; i++) push(8'($urandom));
        @(negedge clk); #1; r0 = clk1_rises;
        bus_write(2'd1, 8'h01);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (clk1_rises - r0 >= 10) break;
        end
        checks++; if (clk1_rises - r0 < 10) begin errors++; $display("FAIL abort_reach got=%0d pulses exp>=10", clk1_rises - r0); end
        bus_write(2'd1, 8'h02);
        #1;
        checks++; if ({nrf_cs, nrf_clk1, nrf_data} !== 3'b000)
            begin errors++; $display("FAIL abort_pins got=%b exp=000", {nrf_cs, nrf_clk1, nrf_data}); end
        bus_read(2'd2, r); checks++; if (r !== 8'h04) begin errors++; $display("FAIL abort_status got=%h exp=04", r); end
        model_q.delete();
        push(8'h5A);
        bus_write(2'd1, 8'h03);
        repeat (4) @(negedge clk);
        bus_read(2'd2, r); checks++; if (r !== 8'h04 || nrf_cs !== 1'b0)
            begin errors++; $display("FAIL abort_with_start status=%h cs=%b exp=04/0", r, nrf_cs); end
        model_q.delete();
        bus_write(2'd1, 8'h01);
        repeat (3) @(negedge clk);
        bus_read(2'd2, r); checks++; if (r !== 8'h04 || nrf_cs !== 1'b0)
            begin errors++; $display("FAIL start_empty status=%h cs=%b exp=04/0", r, nrf_cs); end
    endtask

    task automatic test_async_reset;
        logic [7:0] r;
        bus_write(2'd3, 8'h02);
        push(8'hFF); push(8'hFF);
        bus_write(2'd1, 8'h01);
        repeat (12) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({nrf_cs, nrf_clk1, nrf_data, irq} !== 4'b0)
            begin errors++; $display("FAIL areset_pins got=%b exp=0000", {nrf_cs, nrf_clk1, nrf_data, irq}); end
        @(negedge clk); reset_n = 1'b1;
        model_q.delete();
        bus_read(2'd2, r); checks++; if (r !== 8'h04) begin errors++; $display("FAIL areset_status got=%h exp=04", r); end
        bus_read(2'd3, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL areset_clkdiv got=%h exp=00", r); end
    endtask

    task automatic test_ce;
        logic [7:0] r;
`ifdef NRF_CE_CTRL_EN
        int n, cyc, rises, wins, be, we, ci0, f0; bit ok;
        bus_write(2'd1, 8'h04);
        repeat (2) @(negedge clk);
        checks++; if (nrf_ce !== 1'b1) begin errors++; $display("FAIL ce_idle got=%b exp=1", nrf_ce); end
        bus_read(2'd1, r); checks++; if (r !== 8'h04) begin errors++; $display("FAIL ce_ctrl got=%h exp=04", r); end
        ci0 = ce_in_cs; f0 = cs_falls;
        push(8'h3C);
        run_frame(0, 1'b0, 8'h00, 8'h05, n, cyc, rises, wins, be, we, ok);
        checks++; if (!ok || ce_in_cs != ci0 || cs_falls != f0 + 1)
            begin errors++; $display("FAIL ce_frame ok=%0b ce_high_in_cs=%0d falls=%0d exp 0/1", ok, ce_in_cs - ci0, cs_falls - f0); end
        checks++; if (ce_at_fall !== 1'b0 || ce_after_fall !== 1'b1)
            begin errors++; $display("FAIL ce_restore at_fall=%b after=%b exp=0/1", ce_at_fall, ce_after_fall); end
        bus_write(2'd2, 8'h10);
`else
        bus_write(2'd1, 8'h04);
        repeat (2) @(negedge clk);
        bus_read(2'd1, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL ce_ctrl got=%h exp=00", r); end
        checks++; if (nrf_ce !== 1'b0 || ce_high != 0)
            begin errors++; $display("FAIL ce_tied got=%b high_cycles=%0d exp=0/0", nrf_ce, ce_high); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_random_frames();
        test_overflow();
        test_abort();
        test_async_reset();
        test_ce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
